// File: rtl/shake_pkg.sv
// Shared definitions for the SHAKE256 message loader.
// Holds the rate-block geometry, the SHAKE padding bytes and the loader state type.
// Optional feature macro used by the importing files: SHAKE_PAD_EN.
package shake_pkg;

   // Bytes and bits in one SHAKE256 rate block.
   localparam int unsigned RATE_BYTES = 136;
   localparam int unsigned RATE_BITS  = RATE_BYTES * 8;
   // Width of the data-bit length field; must hold RATE_BITS.
   localparam int unsigned LEN_W      = 11;

   // SHAKE domain-separation byte and final padding bit.
   localparam logic [7:0] SHAKE_DS = 8'h1F;
   localparam logic [7:0] PAD_END  = 8'h80;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      HOLD   = 2'd1,
      PADBLK = 2'd2
   } loader_state_t;

endpackage

// File: rtl/shake_byte_packer.sv
// Rate-block storage for the SHAKE256 message loader.
// A byte-addressed write into the 1088-bit block register with a synchronous clear.
// With SHAKE_PAD_EN defined, the closing write can also OR in the SHAKE padding and a
// pad-only block can be loaded in place of the clear.
// Ports:
//   clock, reset        clock and asynchronous active-low reset
//   wr_en_i             write wr_byte_i into slot wr_idx_i
//   wr_idx_i, wr_byte_i byte slot and byte value
//   clr_i               zero the whole block
//   pad_i               (SHAKE_PAD_EN) pad after the byte being written
//   pad_blk_i           (SHAKE_PAD_EN) load the pad-only block
//   message_o           registered block, byte i at bits [8i+7:8i]
module shake_byte_packer
   import shake_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wr_en_i,
   input  logic [7:0]           wr_idx_i,
   input  logic [7:0]           wr_byte_i,
   input  logic                 clr_i,
`ifdef SHAKE_PAD_EN
   input  logic                 pad_i,
   input  logic                 pad_blk_i,
`endif
   output logic [RATE_BITS-1:0] message_o
);

   logic [RATE_BITS-1:0] msg_d, msg_q;
   int unsigned          slot;

   always_comb begin
      msg_d = msg_q;
      slot  = 32'(wr_idx_i);
      if (clr_i) begin
         msg_d = '0;
      end
`ifdef SHAKE_PAD_EN
      if (pad_blk_i) begin
         msg_d[7:0]             = SHAKE_DS;
         msg_d[RATE_BITS-1 -: 8] = PAD_END;
      end
`endif
      if (wr_en_i && (slot < RATE_BYTES)) begin
         msg_d[slot*8 +: 8] = wr_byte_i;
`ifdef SHAKE_PAD_EN
         // A closing byte in the last slot leaves no room; the pad goes in an extra block.
         // Closing in slot 134 merges both pad bytes into slot 135 (0x9F).
         if (pad_i && (slot < RATE_BYTES - 1)) begin
            msg_d[(slot+1)*8 +: 8]  = msg_d[(slot+1)*8 +: 8] | SHAKE_DS;
            msg_d[RATE_BITS-1 -: 8] = msg_d[RATE_BITS-1 -: 8] | PAD_END;
         end
`endif
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         msg_q <= '0;
      end else begin
         msg_q <= msg_d;
      end
   end

   assign message_o = msg_q;

endmodule

// File: rtl/shake256_msg_loader.sv
// SHAKE256 message loader: packs a valid/ready byte stream into 136-byte rate blocks
// and hands each block to the core with a valid/ready handshake and a last-block flag.
// Optional feature: define SHAKE_PAD_EN to apply SHAKE256 padding in the final block,
// including an extra pad-only block when the final data block is exactly full.
// Ports:
//   clock, reset              clock and asynchronous active-low reset
//   in_data/in_valid/in_last  byte stream in; in_last marks the final message byte
//   in_ready                  loader accepts a byte this cycle
//   message, length           packed block and its count of data bits (0..1088)
//   msg_valid/msg_last        block valid, block is the final one of the message
//   msg_ready                 consumer takes the block
//   byte_count                bytes held in the current block
module shake256_msg_loader
   import shake_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [RATE_BITS-1:0] message,
   output logic [LEN_W-1:0]     length,
   output logic                 msg_valid,
   output logic                 msg_last,
   input  logic                 msg_ready,
   output logic [7:0]           byte_count
);

   loader_state_t    state_q;
   logic [7:0]       byte_count_q;
   logic [LEN_W-1:0] length_q;
   logic             msg_valid_q;
   logic             msg_last_q;
   logic             in_ready_q;

   logic             accept;
   logic             closing;
   logic             handoff;
   logic             full_last;
   logic [LEN_W-1:0] len_close;

   // in_ready_q is high exactly in FILL, so it doubles as the accept qualifier.
   assign accept    = in_valid & in_ready_q;
   assign closing   = accept & (in_last | (byte_count_q == 8'(RATE_BYTES - 1)));
   assign handoff   = msg_valid_q & msg_ready;
   assign full_last = msg_last_q & (length_q == LEN_W'(RATE_BITS));
   assign len_close = (LEN_W'(byte_count_q) + LEN_W'(1)) << 3;

   shake_byte_packer u_packer (
      .clock     (clock),
      .reset     (reset),
      .wr_en_i   (accept),
      .wr_idx_i  (byte_count_q),
      .wr_byte_i (in_data),
      .clr_i     (handoff),
`ifdef SHAKE_PAD_EN
      .pad_i     (closing & in_last),
      .pad_blk_i (handoff & (state_q == HOLD) & full_last),
`endif
      .message_o (message)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= FILL;
         byte_count_q <= '0;
         length_q     <= '0;
         msg_valid_q  <= 1'b0;
         msg_last_q   <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         case (state_q)
            FILL: begin
               if (accept) begin
                  byte_count_q <= byte_count_q + 8'd1;
               end
               if (closing) begin
                  state_q     <= HOLD;
                  length_q    <= len_close;
                  msg_last_q  <= in_last;
                  msg_valid_q <= 1'b1;
                  in_ready_q  <= 1'b0;
               end
            end
            HOLD: begin
               if (handoff) begin
                  byte_count_q <= '0;
`ifdef SHAKE_PAD_EN
                  if (full_last) begin
                     // Pad-only block: no data bits, still the final block.
                     state_q  <= PADBLK;
                     length_q <= '0;
                  end else begin
                     state_q     <= FILL;
                     msg_valid_q <= 1'b0;
                     msg_last_q  <= 1'b0;
                     in_ready_q  <= 1'b1;
                  end
`else
                  state_q     <= FILL;
                  msg_valid_q <= 1'b0;
                  msg_last_q  <= 1'b0;
                  in_ready_q  <= 1'b1;
`endif
               end
            end
`ifdef SHAKE_PAD_EN
            PADBLK: begin
               if (handoff) begin
                  state_q     <= FILL;
                  msg_valid_q <= 1'b0;
                  msg_last_q  <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
`endif
            default: begin
               state_q     <= FILL;
               msg_valid_q <= 1'b0;
               msg_last_q  <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign length     = length_q;
   assign msg_valid  = msg_valid_q;
   assign msg_last   = msg_last_q;
   assign byte_count = byte_count_q;

endmodule
